// File: rtl/cic_gain_ctrl.sv
// Automatic gain controller for the CIC decimator: windowed peak detection on the
// decimated output, single-step gain correction, and a clamped manual-gain bypass.
module cic_gain_ctrl #(
    parameter int DATA_WIDTH     = 12,
    parameter int GAIN_WIDTH     = 8,
    parameter int GAIN_MAX       = 52,
    parameter int GAIN_INIT      = 0,
    parameter int WINDOW_LOG2    = 8,
    parameter int SETTLE_SAMPLES = 4,
    parameter int HIGH_THRESH    = 1536,
    parameter int LOW_THRESH     = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [GAIN_WIDTH-1:0]        manual_gain,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_clk,
    output logic [GAIN_WIDTH-1:0]        gain,
    output logic                         locked,
    output logic [DATA_WIDTH-1:0]        peak,
    output logic                         window_done,
    output logic                         clip
);

    localparam int SET_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam logic [GAIN_WIDTH-1:0] GMAX        = GAIN_WIDTH'(GAIN_MAX);
    localparam logic [GAIN_WIDTH-1:0] GINIT       = GAIN_WIDTH'(GAIN_INIT);
    localparam logic [DATA_WIDTH-1:0] POS_FS      = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_FS      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] HI_TH       = DATA_WIDTH'(HIGH_THRESH);
    localparam logic [DATA_WIDTH-1:0] LO_TH       = DATA_WIDTH'(LOW_THRESH);
    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_SAMPLES - 1);

    typedef enum logic [1:0] {MANUAL, SETTLE, MEASURE, ADJUST} state_t;

    // |x| computed one bit wider, then saturated so -full-scale maps to +full-scale
    function automatic logic [DATA_WIDTH-1:0] sat_mag(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH:0] ext;
        logic [DATA_WIDTH-1:0]      mag_u;
        ext   = (DATA_WIDTH+1)'(x);
        mag_u = ext[DATA_WIDTH] ? DATA_WIDTH'(-ext) : DATA_WIDTH'(ext);
        return mag_u[DATA_WIDTH-1] ? POS_FS : mag_u;
    endfunction

    function automatic logic is_full_scale(input logic signed [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] bits_u;
        bits_u = x;
        return (bits_u == POS_FS) || (bits_u == NEG_FS);
    endfunction

    function automatic logic [GAIN_WIDTH-1:0] clamp_gain(input logic [GAIN_WIDTH-1:0] g);
        return (g > GMAX) ? GMAX : g;
    endfunction

    function automatic logic [GAIN_WIDTH-1:0] step_down(input logic [GAIN_WIDTH-1:0] g);
        return (g == '0) ? '0 : g - GAIN_WIDTH'(1);
    endfunction

    function automatic logic [GAIN_WIDTH-1:0] step_up(input logic [GAIN_WIDTH-1:0] g);
        return (g >= GMAX) ? GMAX : g + GAIN_WIDTH'(1);
    endfunction

    state_t                  state, state_next;
    logic                    data_clk_q;
    logic                    stb;
    logic [SET_W-1:0]        settle_cnt;
    logic [WINDOW_LOG2-1:0]  win_cnt;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    clip_flag;
    logic [DATA_WIDTH-1:0]   mag;
    logic                    full_scale;
    logic                    win_last;
    logic                    settle_last;
    logic [GAIN_WIDTH-1:0]   gain_adj;

    assign stb         = data_clk & ~data_clk_q;
    assign mag         = sat_mag(data_in);
    assign full_scale  = is_full_scale(data_in);
    assign win_last    = &win_cnt;
    assign settle_last = (settle_cnt == SETTLE_LAST);

    always_comb begin
        gain_adj = gain;
        if (clip_flag || (acc > HI_TH)) begin
            gain_adj = step_down(gain);
        end else if (acc < LO_TH) begin
            gain_adj = step_up(gain);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MANUAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MANUAL:  if (enable) state_next = SETTLE;
            SETTLE:  if (stb && settle_last) state_next = MEASURE;
            MEASURE: if (stb && (full_scale || win_last)) state_next = ADJUST;
            ADJUST:  state_next = (gain_adj != gain) ? SETTLE : MEASURE;
            default: state_next = MANUAL;
        endcase
        if (!enable) begin
            state_next = MANUAL;
        end
    end

    // accumulator is cleared on every entry to MEASURE, so it needs no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_clk_q  <= 1'b0;
            gain        <= GINIT;
            locked      <= 1'b0;
            peak        <= '0;
            window_done <= 1'b0;
            clip        <= 1'b0;
            settle_cnt  <= '0;
            win_cnt     <= '0;
            clip_flag   <= 1'b0;
        end else begin
            data_clk_q  <= data_clk;
            window_done <= 1'b0;
            clip        <= 1'b0;
            if (!enable) begin
                locked     <= 1'b0;
                acc        <= '0;
                settle_cnt <= '0;
                win_cnt    <= '0;
                clip_flag  <= 1'b0;
                if (state == MANUAL) begin
                    gain <= clamp_gain(manual_gain);
                end
            end else begin
                case (state)
                    MANUAL: begin
                        gain       <= clamp_gain(manual_gain);
                        locked     <= 1'b0;
                        settle_cnt <= '0;
                    end
                    SETTLE: begin
                        if (stb) begin
                            if (settle_last) begin
                                settle_cnt <= '0;
                                acc        <= '0;
                                win_cnt    <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + SET_W'(1);
                            end
                        end
                    end
                    MEASURE: begin
                        if (stb) begin
                            acc     <= (mag > acc) ? mag : acc;
                            win_cnt <= win_cnt + WINDOW_LOG2'(1);
                            if (full_scale) begin
                                clip      <= 1'b1;
                                clip_flag <= 1'b1;
                            end
                        end
                    end
                    ADJUST: begin
                        peak        <= acc;
                        window_done <= 1'b1;
                        gain        <= gain_adj;
                        locked      <= (gain_adj == gain) && !clip_flag;
                        clip_flag   <= 1'b0;
                        acc         <= '0;
                        win_cnt     <= '0;
                        settle_cnt  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cic_gain_ctrl.sv
// Bench for cic_gain_ctrl: sample-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cic_gain_ctrl;

    localparam int DW = 12;
    localparam int GW = 8;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic [GW-1:0]        manual_gain;
    logic signed [DW-1:0] data_in;
    logic                 data_clk;
    logic [GW-1:0]        gain;
    logic                 locked;
    logic [DW-1:0]        peak;
    logic                 window_done;
    logic                 clip;

    int errors = 0;
    int checks = 0;

    cic_gain_ctrl #(
        .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .GAIN_MAX(52), .GAIN_INIT(0),
        .WINDOW_LOG2(2), .SETTLE_SAMPLES(2), .HIGH_THRESH(1536), .LOW_THRESH(512)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .manual_gain(manual_gain),
        .data_in(data_in), .data_clk(data_clk), .gain(gain), .locked(locked),
        .peak(peak), .window_done(window_done), .clip(clip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // decimated sample source: data_clk 8 cycles high, 8 low
    int rise_cnt = 0;
    int clip_at  = -1;
    bit pat_alt  = 1'b0;
    int pat_val  = 0;
    initial begin
        data_clk = 1'b0;
        data_in  = '0;
        forever begin
            repeat (8) @(posedge clk);
            #2;
            if (!data_clk) begin
                rise_cnt++;
                if (rise_cnt == clip_at)
                    data_in = DW'(-2048);
                else if (pat_alt && (rise_cnt % 2 == 0))
                    data_in = DW'(-pat_val);
                else
                    data_in = DW'(pat_val);
            end
            data_clk = ~data_clk;
        end
    end

    // reference model: tracks decimated samples in a queue, evaluates the window rules
    typedef enum int {M_MAN, M_SET, M_MEAS, M_ADJ} mmode_t;
    mmode_t     m_mode = M_MAN;
    bit         model_ok = 1'b0;
    bit         m_prev = 1'b0;
    bit         m_stb;
    bit         m_clip = 1'b0;
    int         m_settle_left = 0;
    int         m_win[$];
    logic [GW-1:0] e_gain = '0;
    logic          e_locked = 1'b0;
    logic [DW-1:0] e_peak = '0;
    logic          e_wd = 1'b0;
    logic          e_clip = 1'b0;

    function automatic int mag_of(input logic signed [DW-1:0] x);
        int v;
        v = x;
        if (v < 0) v = -v;
        return (v > 2047) ? 2047 : v;
    endfunction

    function automatic logic [GW-1:0] clampg(input logic [GW-1:0] g);
        return (g > 8'd52) ? 8'd52 : g;
    endfunction

    always @(posedge clk) begin
        int pk;
        int g;
        int ng;
        m_stb  = data_clk && !m_prev;
        e_wd   = 1'b0;
        e_clip = 1'b0;
        if (rst) begin
            e_gain = '0; e_locked = 1'b0; e_peak = '0;
            m_mode = M_MAN; m_prev = 1'b0; m_clip = 1'b0;
            m_win.delete();
            model_ok = 1'b1;
        end else begin
            m_prev = data_clk;
            if (!enable) begin
                if (m_mode == M_MAN) e_gain = clampg(manual_gain);
                e_locked = 1'b0;
                m_mode = M_MAN;
                m_clip = 1'b0;
                m_win.delete();
            end else begin
                case (m_mode)
                    M_MAN: begin
                        e_gain = clampg(manual_gain);
                        e_locked = 1'b0;
                        m_settle_left = 2;
                        m_mode = M_SET;
                    end
                    M_SET: if (m_stb) begin
                        m_settle_left--;
                        if (m_settle_left == 0) begin
                            m_win.delete();
                            m_mode = M_MEAS;
                        end
                    end
                    M_MEAS: if (m_stb) begin
                        m_win.push_back(mag_of(data_in));
                        if (data_in == DW'(2047) || data_in == DW'(-2048)) begin
                            e_clip = 1'b1;
                            m_clip = 1'b1;
                            m_mode = M_ADJ;
                        end else if (m_win.size() == 4) begin
                            m_mode = M_ADJ;
                        end
                    end
                    M_ADJ: begin
                        pk = 0;
                        foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
                        g = int'(e_gain);
                        if (m_clip || pk > 1536)  ng = (g > 0) ? g - 1 : 0;
                        else if (pk < 512)        ng = (g < 52) ? g + 1 : 52;
                        else                      ng = g;
                        e_peak   = DW'(pk);
                        e_wd     = 1'b1;
                        e_locked = (ng == g) && !m_clip;
                        e_gain   = GW'(ng);
                        m_clip   = 1'b0;
                        m_win.delete();
                        if (ng != g) begin
                            m_settle_left = 2;
                            m_mode = M_SET;
                        end else begin
                            m_mode = M_MEAS;
                        end
                    end
                    default: m_mode = M_MAN;
                endcase
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (gain !== e_gain || locked !== e_locked || peak !== e_peak ||
                window_done !== e_wd || clip !== e_clip) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got gain=%0d locked=%0b peak=%0d wd=%0b clip=%0b, required gain=%0d locked=%0b peak=%0d wd=%0b clip=%0b",
                         $time, gain, locked, peak, window_done, clip,
                         e_gain, e_locked, e_peak, e_wd, e_clip);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_wd(input string name, input int bound, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!window_done && cyc < bound);
        if (!window_done) begin
            checks++;
            errors++;
            $display("FAIL %s: no window_done within %0d cycles", name, cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int nwd;
        rst = 1'b1;
        enable = 1'b0;
        manual_gain = 8'd0;

        // reset held for two cycles with inputs moving
        repeat (2) begin
            @(posedge clk); #2;
            enable = ~enable;
            manual_gain = 8'($urandom_range(0, 255));
        end
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("reset_gain", gain, 0);
        chk("reset_locked", locked, 0);
        chk("reset_peak", peak, 0);
        chk("reset_wd", window_done, 0);
        chk("reset_clip", clip, 0);

        // manual clamp
        @(posedge clk); #2; manual_gain = 8'd60;
        @(posedge clk); @(negedge clk);
        chk("manual_clamp", gain, 52);
        @(posedge clk); #2; manual_gain = 8'd10;
        @(posedge clk); @(negedge clk);
        chk("manual_pass", gain, 10);

        // low signal: gain climbs one step per settle+window
        pat_alt = 1'b0;
        pat_val = 100;
        @(posedge data_clk);
        @(posedge clk); #2;
        enable = 1'b1;
        base = rise_cnt;
        wait_wd("low_first_wd", 400, cyc);
        chk("low_first_strobes", rise_cnt - base, 6);
        chk("low_first_peak", peak, 100);
        chk("low_first_gain", gain, 11);
        chk("low_first_locked", locked, 0);
        nwd = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (window_done) nwd++;
        end while (!(gain == 8'd52 && locked) && cyc < 6000);
        chk("low_windows_to_lock", nwd, 42);
        chk("low_final_gain", gain, 52);
        chk("low_final_locked", locked, 1);

        // in-band alternating traffic
        @(posedge clk); #2;
        pat_alt = 1'b1;
        pat_val = 1000;
        wait_wd("band_wd", 200, cyc);
        chk("band_peak", peak, 1000);
        chk("band_gain", gain, 52);
        chk("band_locked", locked, 1);
        wait_wd("band_wd2", 200, cyc);
        chk("band_no_settle_gap", cyc, 64);

        // clip on 2nd sample of the next window
        clip_at = rise_cnt + 2;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!clip && cyc < 100);
        chk("clip_pulse", clip, 1);
        @(negedge clk);
        chk("clip_wd", window_done, 1);
        chk("clip_peak", peak, 2047);
        chk("clip_gain", gain, 51);
        chk("clip_locked", locked, 0);
        wait_wd("post_clip_wd", 200, cyc);
        chk("post_clip_settle_gap", cyc, 96);
        chk("post_clip_locked", locked, 1);

        // disable mid-window
        repeat (40) @(posedge clk);
        #2;
        enable = 1'b0;
        manual_gain = 8'd5;
        @(posedge clk); @(negedge clk);
        chk("disable_locked", locked, 0);
        chk("disable_gain_hold", gain, 51);
        @(negedge clk);
        chk("disable_gain_manual", gain, 5);
        nwd = 0;
        repeat (100) begin
            @(negedge clk);
            if (window_done) nwd++;
        end
        chk("disable_no_wd", nwd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_gain_ctrl.md
# cic_gain_ctrl

Automatic gain controller for the CIC decimator. Sits beside the CIC and watches its decimated output (`data_out`, `data_clk`). Measures the peak magnitude over a window of decimated samples, then steps the CIC `gain` input up or down one unit at a time. The goal is to keep the output peak inside a target band without clipping. With `enable` low it passes a software-set manual gain through, clamped to a legal range.

## Interface
- `DATA_WIDTH`, 12: width of the CIC output sample being monitored.
- `GAIN_WIDTH`, 8: width of the gain word driven to the CIC.
- `GAIN_MAX`, 52: highest legal gain (CIC register width minus data width). All gain outputs are clamped to 0..GAIN_MAX.
- `GAIN_INIT`, 0: gain value driven out of reset.
- `WINDOW_LOG2`, 8: measurement window is 2^WINDOW_LOG2 decimated samples.
- `SETTLE_SAMPLES`, 4: decimated samples discarded after every gain change or enable.
- `HIGH_THRESH`, 1536: a window peak above this value reduces gain.
- `LOW_THRESH`, 512: a window peak below this value raises gain.
- `clk` in 1: system clock, same clock as the CIC.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 1 = automatic control, 0 = manual gain.
- `manual_gain` in GAIN_WIDTH: gain requested while `enable`=0.
- `data_in` in DATA_WIDTH, signed: the CIC `data_out`.
- `data_clk` in 1: the CIC decimated-data clock (level; its rising edge marks a new sample).
- `gain` out GAIN_WIDTH: registered gain to the CIC `gain` input.
- `locked` out 1: high after a window that left gain unchanged.
- `peak` out DATA_WIDTH, unsigned: peak magnitude of the last completed window.
- `window_done` out 1: one-cycle pulse when a window closes or a clip aborts it.
- `clip` out 1: one-cycle pulse on a full-scale sample.

## Operation
- Sample strobe: `stb` = `data_clk` & ~`data_clk_q`, where `data_clk_q` is `data_clk` registered one cycle.
  - `data_in` is captured only in the `stb` cycle.
  - `data_in` is stable for the whole decimated period.
- Magnitude: `mag` = `data_in`<0 ? -`data_in` : `data_in`, computed DATA_WIDTH+1 bits wide, then saturated to 2^(DATA_WIDTH-1)-1.
- Clip condition: `data_in` equals 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1).
- FSM states: MANUAL, SETTLE, MEASURE, ADJUST.
- MANUAL:
  - `gain` <= min(`manual_gain`, GAIN_MAX) every cycle; `locked`=0.
  - `enable`=1 → SETTLE, with the settle counter cleared.
- SETTLE:
  - Count `stb`s. After SETTLE_SAMPLES strobes → MEASURE, with peak accumulator and window counter cleared.
  - A clip in SETTLE is ignored.
- MEASURE:
  - On each `stb`, accumulator <= max(accumulator, `mag`).
  - Counter reaches 2^WINDOW_LOG2 samples (the last sample is included) → ADJUST.
  - Clip on a `stb` → `clip` pulse, immediate ADJUST with the clip flag set. The partial window's peak, including the clip sample, is used.
- ADJUST (exactly one cycle):
  - `peak` <= accumulator; `window_done` pulses.
  - If clip flag or `peak` > HIGH_THRESH: `gain` <= `gain`-1, floored at 0.
  - Else if `peak` < LOW_THRESH: `gain` <= `gain`+1, capped at GAIN_MAX.
  - Else `gain` is unchanged.
  - `locked` <= 1 iff `gain` is unchanged and the clip flag is clear. This includes a saturated step at the 0 or GAIN_MAX bound.
  - `gain` changed → SETTLE; unchanged → MEASURE.
  - Clip flag and accumulator are cleared on exit.
- `enable`=0 in any state → MANUAL next cycle. That cycle `locked` clears and accumulator/counters clear; `gain` follows `manual_gain` from then on.
- Threshold comparisons are strict. `peak` equal to either threshold is in-band.

## Timing
- Reset values: `gain`=GAIN_INIT, `locked`=0, `peak`=0, `window_done`=0, `clip`=0. State MANUAL, all counters and `data_clk_q` = 0.
- `rst` has priority over everything. Asserting it mid-window discards the window with no `window_done`.
- MANUAL tracking: a `manual_gain` change appears on `gain` 1 cycle later.
- `stb` occurs 1 cycle after the `data_clk` rising edge is presented.
- `clip` pulses in the `stb` cycle that captures the clip sample. `window_done` and the new `gain` follow 1 cycle later (from ADJUST). The CIC sees the new gain 2 cycles after the clip sample's `stb`.
- Window close: the last `stb` is followed by ADJUST on the next cycle. `gain`, `peak`, `locked` and `window_done` all update together on the ADJUST clock edge.
- ADJUST cannot coincide with `stb`: the CIC decimation ratio is ≥2, so `stb`s are ≥2 cycles apart.
- Gain changes by at most 1 per window or per clip event.

## Test plan
All scenarios use WINDOW_LOG2=2, SETTLE_SAMPLES=2, and `data_clk` pulsing 8 cycles high, 8 low.
- Reset: hold `rst` 2 cycles with toggling inputs → `gain`=0, `locked`=0, `peak`=0, no pulses.
- Manual clamp: `enable`=0, `manual_gain`=60 → `gain`=52 one cycle later; `manual_gain`=10 → `gain`=10.
- Low signal: `enable`=1 from `gain`=10, `data_in`=100 constant →
  - first `window_done` after 2+4 strobes, `peak`=100, `gain`=11, `locked`=0;
  - `gain` keeps stepping every 6 strobes and stops at 52 with `locked`=1.
- In band: `data_in` alternating +1000/-1000 → first window `peak`=1000, `gain` unchanged, `locked`=1; next window starts with no settle.
- Clip: in-band traffic, then `data_in`=-2048 on the 2nd sample of a window → `clip` pulse, `peak`=2047, `gain` decremented, `locked`=0, SETTLE re-entered.
- Disable mid-MEASURE with `manual_gain`=5 → next cycle state MANUAL, `locked`=0, and the cycle after that `gain`=5; no `window_done`.
